// File: rtl/proz_pkg.sv
// Shared encodings for the instruction sequencer: opcodes, instruction field
// positions, controller states and decoded instruction classes.
package proz_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_ALU, C_LDI, C_JMP, C_BZ, C_HALT
  } iclass_t;

  // Opcodes 0xB-0xE are reserved and execute as NOP.
  function automatic iclass_t op_class(input logic [3:0] op);
    case (op)
      OP_LDI:  return C_LDI;
      OP_JMP:  return C_JMP;
      OP_BZ:   return C_BZ;
      OP_HALT: return C_HALT;
      default: return (op != OP_NOP && !op[3]) ? C_ALU : C_NOP;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational split of the instruction register into class and fields.
module instr_decoder
  import proz_pkg::*;
(
  input  logic [15:0] ir,
  output iclass_t     iclass,
  output logic [2:0]  alu_op,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [7:0]  imm8
);

  assign iclass = op_class(ir[OP_MSB:OP_LSB]);
  assign alu_op = ir[OP_LSB+2:OP_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rs1    = ir[RS1_MSB:RS1_LSB];
  assign rs2    = ir[RS2_MSB:RS2_LSB];
  assign imm8   = ir[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches over a req/ack port, decodes,
// drives an external ALU and register bank, and stops on HALT.
module instr_sequencer
  import proz_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [2:0]  addr1,
  output logic [2:0]  addr2,
  output logic [2:0]  addrdest,
  input  logic [7:0]  data1,
  input  logic [7:0]  data2,
  output logic [7:0]  datadest,
  output logic        control,
  output logic [7:0]  a1,
  output logic [7:0]  a2,
  output logic [2:0]  alu_ctrl,
  input  logic [7:0]  o,
  input  logic [3:0]  status,
  output logic        halted
);

  state_t      state, state_nxt;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        zflag;
  iclass_t     iclass;
  logic [2:0]  alu_op;
  logic [7:0]  imm8;
  logic        unused_status;

  assign unused_status = &{1'b0, status[3:1]};

  instr_decoder u_dec (
    .ir     (ir),
    .iclass (iclass),
    .alu_op (alu_op),
    .rd     (addrdest),
    .rs1    (addr1),
    .rs2    (addr2),
    .imm8   (imm8)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (enable) state_nxt = S_FETCH;
      S_FETCH:     if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        case (iclass)
          C_HALT:       state_nxt = S_HALT;
          C_ALU, C_LDI: state_nxt = S_EXECUTE;
          default:      state_nxt = S_IDLE;
        endcase
      end
      S_EXECUTE:   state_nxt = S_WRITEBACK;
      S_WRITEBACK: state_nxt = S_IDLE;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // pc advances in DECODE for every instruction except a taken branch and HALT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      ir       <= '0;
      zflag    <= 1'b0;
      a1       <= '0;
      a2       <= '0;
      alu_ctrl <= '0;
    end else begin
      if (state == S_FETCH && imem_ack) ir <= imem_data;
      if (state == S_DECODE) begin
        case (iclass)
          C_JMP:   pc <= imm8;
          C_BZ:    pc <= zflag ? imm8 : pc + 8'd1;
          C_HALT:  pc <= pc;
          default: pc <= pc + 8'd1;
        endcase
      end
      if (state == S_EXECUTE && iclass == C_ALU) begin
        a1       <= data1;
        a2       <= data2;
        alu_ctrl <= alu_op;
      end
      if (state == S_WRITEBACK && iclass == C_ALU) zflag <= status[0];
    end
  end

  always_comb begin
    imem_req  = (state == S_FETCH);
    imem_addr = pc;
    control   = (state == S_WRITEBACK);
    halted    = (state == S_HALT);
    datadest  = '0;
    if (state == S_WRITEBACK) datadest = (iclass == C_ALU) ? o : imm8;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: expected fetch addresses and register writes are queued by
// the stimulus, and a negedge monitor checks them as the DUT presents them.
module tb_instr_sequencer;

  localparam logic [15:0] JUNK = 16'hEE00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data = JUNK;
  logic [2:0]  addr1, addr2, addrdest;
  logic [7:0]  data1, data2, datadest;
  logic        control;
  logic [7:0]  a1, a2;
  logic [2:0]  alu_ctrl;
  logic [7:0]  o;
  logic [3:0]  status;
  logic        halted;

  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  int          ack_delay = 0;
  int          wait_cnt = 0;

  logic [15:0] mem [256];
  logic [7:0]  regs [8];

  typedef struct { logic [7:0] addr; int gap; } fetch_t;
  typedef struct { logic [2:0] rd; logic [7:0] data; bit alu;
                   logic [7:0] a1; logic [7:0] a2; logic [2:0] ctrl; } wr_t;
  fetch_t exp_fetch[$];
  wr_t    exp_wr[$];

  int errors = 0;
  int checks = 0;
  bit chk_len = 1'b0;
  int exp_len = 1;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .addr1(addr1), .addr2(addr2), .addrdest(addrdest),
    .data1(data1), .data2(data2), .datadest(datadest), .control(control),
    .a1(a1), .a2(a2), .alu_ctrl(alu_ctrl), .o(o), .status(status), .halted(halted)
  );

  always #5 clk = ~clk;

  assign imem_ack = resp_ack | stray_ack;
  assign data1 = regs[addr1];
  assign data2 = regs[addr2];

  always_comb begin
    case (alu_ctrl)
      3'd1:    o = a1 + a2;
      3'd2:    o = a1 - a2;
      3'd3:    o = a1 & a2;
      3'd4:    o = a1 | a2;
      3'd5:    o = a1 ^ a2;
      default: o = a1;
    endcase
    status = {3'b000, o == 8'h00};
  end

  always @(posedge clk) if (control) regs[addrdest] <= datadest;

  // Memory responder: ack after ack_delay wait cycles, junk data otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (resp_ack) begin
        resp_ack = 1'b0;
        imem_data = JUNK;
      end else if (imem_req) begin
        if (wait_cnt == ack_delay) begin
          resp_ack = 1'b1;
          imem_data = mem[imem_addr];
          wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  int         cyc = 0;
  int         last_rise = 0;
  int         req_len = 0;
  logic       prev_req = 1'b0;
  logic       prev_ctrl = 1'b0;
  logic [7:0] held_addr;
  logic [2:0] held_rd;

  always @(negedge clk) begin
    fetch_t f;
    wr_t w;
    cyc++;
    if (imem_req) begin
      if (!prev_req) begin
        check("fetch_no_ctrl", 32'(control), 32'd0);
        if (exp_fetch.size() == 0) check("fetch_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
        else begin
          f = exp_fetch.pop_front();
          check("fetch_addr", 32'(imem_addr), 32'(f.addr));
          if (f.gap != 0) check("fetch_gap", 32'(cyc - last_rise), 32'(f.gap));
        end
        last_rise = cyc;
        held_addr = imem_addr;
        held_rd   = addrdest;
        req_len   = 1;
      end else begin
        req_len++;
        check("req_addr_stable", 32'(imem_addr), 32'(held_addr));
        check("ir_hold_in_fetch", 32'(addrdest), 32'(held_rd));
      end
    end else if (prev_req && chk_len) check("req_len", 32'(req_len), 32'(exp_len));
    if (control) begin
      check("ctrl_one_cycle", 32'(prev_ctrl), 32'd0);
      if (exp_wr.size() == 0) check("write_unexpected", 32'(addrdest), 32'hFFFF_FFFF);
      else begin
        w = exp_wr.pop_front();
        check("wr_rd", 32'(addrdest), 32'(w.rd));
        check("wr_data", 32'(datadest), 32'(w.data));
        if (w.alu) begin
          check("wr_a1", 32'(a1), 32'(w.a1));
          check("wr_a2", 32'(a2), 32'(w.a2));
          check("wr_alu_ctrl", 32'(alu_ctrl), 32'(w.ctrl));
        end
      end
    end
    prev_req  = imem_req;
    prev_ctrl = control;
  end

  // which: 0 = imem_req, 1 = control, 2 = halted, 3 = fetch of 0x40
  task automatic wait_for(input int which, input int budget, input string name);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      case (which)
        0: found = imem_req;
        1: found = control;
        2: found = halted;
        default: found = imem_req && imem_addr == 8'h40;
      endcase
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic quiet_cycles(input int n, input string name, input bit exp_halted);
    bit bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (imem_req || control || halted != exp_halted) bad = 1'b1;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic drained(input string name);
    check({name, "_fetch_q"}, 32'(exp_fetch.size()), 32'd0);
    check({name, "_write_q"}, 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_ctrl", 32'(control), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_fields", 32'({addr1, addr2, addrdest}), 32'd0);
    check("rst_datapath", 32'({datadest, a1, a2, alu_ctrl}), 32'd0);
    reset = 1'b0;

    // Phase A: LDI/ALU/branch program, zero-wait ack, pc wrap, then HALT.
    mem[8'h00] = 16'h8205;  // LDI r1,0x05
    mem[8'h01] = 16'h8403;  // LDI r2,0x03
    mem[8'h02] = 16'h1650;  // ADD r3,r1,r2
    mem[8'h03] = 16'h2848;  // SUB r4,r1,r1 -> zero
    mem[8'h04] = 16'hA040;  // BZ 0x40 (taken)
    mem[8'h40] = 16'h1A50;  // ADD r5,r1,r2 -> nonzero
    mem[8'h41] = 16'hA010;  // BZ 0x10 (not taken)
    mem[8'h42] = 16'h90FE;  // JMP 0xFE
    mem[8'hFE] = 16'h0000;  // NOP
    mem[8'hFF] = 16'hB123;  // reserved -> NOP, pc wraps
    exp_fetch.push_back('{8'h00, 0});
    exp_fetch.push_back('{8'h01, 5});
    exp_fetch.push_back('{8'h02, 5});
    exp_fetch.push_back('{8'h03, 5});
    exp_fetch.push_back('{8'h04, 5});
    exp_fetch.push_back('{8'h40, 3});
    exp_fetch.push_back('{8'h41, 5});
    exp_fetch.push_back('{8'h42, 3});
    exp_fetch.push_back('{8'hFE, 3});
    exp_fetch.push_back('{8'hFF, 3});
    exp_fetch.push_back('{8'h00, 3});
    exp_wr.push_back('{3'd1, 8'h05, 1'b0, 8'h00, 8'h00, 3'd0});
    exp_wr.push_back('{3'd2, 8'h03, 1'b0, 8'h00, 8'h00, 3'd0});
    exp_wr.push_back('{3'd3, 8'h08, 1'b1, 8'h05, 8'h03, 3'd1});
    exp_wr.push_back('{3'd4, 8'h00, 1'b1, 8'h05, 8'h05, 3'd2});
    exp_wr.push_back('{3'd5, 8'h08, 1'b1, 8'h05, 8'h03, 3'd1});

    quiet_cycles(10, "idle_without_enable", 1'b0);
    enable = 1'b1;
    @(negedge clk);
    check("enable_to_fetch", 32'(imem_req), 32'd1);
    wait_for(3, 200, "reach_0x40");
    mem[8'h00] = 16'hF000;  // second visit to 0 after the wrap halts
    wait_for(2, 200, "halt_a");
    quiet_cycles(10, "halt_quiet", 1'b1);
    check("regbank_r3", 32'(regs[3]), 32'h08);
    drained("phase_a");

    // Phase B: four-cycle ack delay; enable dropped mid-instruction.
    reset = 1'b1;
    enable = 1'b0;
    #1;
    check("rst_clears_halt", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mem[8'h00] = 16'h8CA5;  // LDI r6,0xA5
    mem[8'h01] = 16'hF000;
    ack_delay = 4;
    chk_len = 1'b1;
    exp_len = 5;
    exp_fetch.push_back('{8'h00, 0});
    exp_fetch.push_back('{8'h01, 0});
    exp_wr.push_back('{3'd6, 8'hA5, 1'b0, 8'h00, 8'h00, 3'd0});
    enable = 1'b1;
    wait_for(0, 10, "fetch_b");
    enable = 1'b0;
    wait_for(1, 30, "write_b");
    quiet_cycles(5, "enable_gates_idle", 1'b0);
    enable = 1'b1;
    wait_for(2, 40, "halt_b");
    drained("phase_b");

    // Phase C: reset mid-fetch, stray ack, reset during writeback.
    reset = 1'b1;
    enable = 1'b0;
    chk_len = 1'b0;
    ack_delay = 3;
    @(negedge clk);
    reset = 1'b0;
    mem[8'h00] = 16'h8E11;  // LDI r7,0x11
    exp_fetch.push_back('{8'h00, 0});
    enable = 1'b1;
    wait_for(0, 10, "fetch_c");
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_fetch_req", 32'(imem_req), 32'd0);
    check("rst_mid_fetch_addr", 32'(imem_addr), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    check("stray_ack_ir", 32'(addrdest), 32'd0);
    check("stray_ack_req", 32'(imem_req), 32'd0);

    exp_fetch.push_back('{8'h00, 0});
    exp_wr.push_back('{3'd7, 8'h11, 1'b0, 8'h00, 8'h00, 3'd0});
    enable = 1'b1;
    wait_for(1, 40, "write_c");
    #2 reset = 1'b1;
    #1;
    check("rst_wb_ctrl", 32'(control), 32'd0);
    check("rst_wb_datadest", 32'(datadest), 32'd0);
    check("rst_wb_pc", 32'(imem_addr), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("wb_suppressed", 32'(regs[7]), 32'd0);

    mem[8'h00] = 16'hF000;
    exp_fetch.push_back('{8'h00, 0});
    enable = 1'b1;
    wait_for(2, 40, "halt_c");
    quiet_cycles(5, "halt_quiet_c", 1'b1);
    drained("phase_c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
